uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Arbiter that shares the single `uart_tx` transmitter between two byte sources:
- **Echo requester (A):** the `uart_rx` output stream. It cannot be back-pressured, so it is buffered in a small FIFO.
- **Message requester (B):** a packet source, e.g. a status/bell reporter, that holds the transmitter for a whole packet.

The block sits between these sources and `uart_tx` in the top level, on the pixel clock. It replaces the direct rx→tx wiring.

## Interface
Parameters:
- `DEPTH`, default 4: echo FIFO depth in bytes. Power of two, ≥2.

Ports:
- `i_clk`  in  1  pixel clock; the only clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_a_data`  in  8  echo byte.
- `i_a_valid`  in  1  one-cycle strobe; no ready is returned.
- `o_a_overflow`  out  1  sticky: an echo byte was dropped.
- `i_b_data`  in  8  message byte.
- `i_b_last`  in  1  marks the final byte of a packet.
- `i_b_valid`  in  1  B handshake valid.
- `o_b_ready`  out  1  B handshake ready.
- `o_data`  out  8  byte to `uart_tx`.
- `o_valid`  out  1  to `uart_tx` `i_valid`.
- `i_ready`  in  1  from `uart_tx` `o_ready`.
- `o_busy`  out  1  high when state ≠ IDLE.

## Operation
Handshakes:
- A B transfer occurs when `i_b_valid && o_b_ready` at a rising edge.
- A downstream transfer occurs when `o_valid && i_ready` at a rising edge.

Echo FIFO:
- An `i_a_valid` write is accepted if count < DEPTH, or if a pop happens in the same cycle.
- Otherwise the byte is dropped and `o_a_overflow` is set.
- Read and write pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

State machine (IDLE, A_SEND, B_LOAD, B_SEND) and round-robin bit `last` (A or B):
- **IDLE.** `A_pend` = FIFO non-empty; `B_pend` = `i_b_valid`.
  - Both pending: grant the requester ≠ `last`.
  - Only one pending: grant it.
  - Neither pending: stay in IDLE.
  - Grant A: pop the FIFO, `o_data` ← head, `o_valid` ← 1, go to A_SEND.
  - Grant B: go to B_LOAD.
- **A_SEND.** Hold `o_data`/`o_valid` until transfer. Then `o_valid` ← 0, `last` ← A, go to IDLE.
- **B_LOAD.** `o_b_ready` = 1. This is the only state where it is high; it is combinational from the state register.
  - On a B transfer: `o_data` ← `i_b_data`, latch `i_b_last`, `o_valid` ← 1, go to B_SEND.
- **B_SEND.** Hold `o_data`/`o_valid` until transfer. Then `o_valid` ← 0.
  - Latched last set: `last` ← B, go to IDLE.
  - Otherwise: go to B_LOAD.
- A B packet is never interleaved with A bytes. A bytes accumulate in the FIFO, and overflow if the packet outlasts DEPTH echo bytes.
- If B deasserts valid mid-packet, the arbiter waits in B_LOAD indefinitely. Ending packets is B's responsibility.
- `o_data` changes only on a load. While `o_valid` = 1, `o_data` is stable.

## Timing
Reset values: state IDLE, `last` = B (so A wins the first tie), FIFO empty, `o_valid` 0, `o_data` 0x00, `o_a_overflow` 0, `o_b_ready` 0, `o_busy` 0.
- Reset is sampled at an edge. Outputs take their reset values after that edge, and any in-flight byte and buffered FIFO contents are discarded.

Latencies:
- **A:** strobe at edge k (write) → FIFO non-empty after k → pop/load at k+1 → `o_valid` high after edge k+1.
- **B first byte:** grant at edge k → `o_b_ready` high after k → transfer at k+1 → `o_valid` high after k+1.
- **B subsequent bytes:** downstream transfer at edge k → `o_b_ready` high after k.

Throughput:
- A: at most one byte per 2 cycles.
- B: at most one byte per 2 cycles, plus one grant cycle per packet.
- The UART byte time (~1416 clocks) dominates both.

Simultaneous events:
- Write and pop in the same cycle: count is unchanged, and a write to a full FIFO is accepted.
- `i_a_valid` during any state is always written subject to the FIFO rule. It never stalls.

## Configuration
- `UART_TX_ARB_DROP_CNT_EN` defined:
  - Adds output `o_a_drops` (8 bits). It increments on each dropped echo byte and saturates at 255.
  - Reset value 0.
- Undefined: the port and counter are absent. `o_a_overflow` is unaffected either way.

## Test plan
- **Single echo:** `i_a_data`=0x41 strobe, `i_ready`=1 → `o_valid` high for one cycle after k+1 with `o_data`=0x41; `o_busy` returns low.
- **Tie:** FIFO holds 0x31 and B presents 0x55/0x56 (last on 0x56), both pending in the same IDLE cycle after reset → output order 0x31, 0x55, 0x56. Next tie grants A again.
- **Packet lock:** B packet 0x10, 0x11, 0x12 (last), with echo strobes 0x61, 0x62 arriving during 0x10 → output 0x10, 0x11, 0x12, 0x61, 0x62.
- **Overflow:** DEPTH=4, `i_ready`=0, 6 echo strobes 0x01–0x06 → the first byte is loaded into `o_data` and 4 bytes are buffered, so one byte (0x06) is dropped and `o_a_overflow`=1. Release `i_ready` → output 0x01–0x05; `o_a_drops`=1 with the macro defined.
- **Full + pop:** FIFO full, echo strobe coincident with a pop → no drop, count stays 4.
- **Reset mid-packet:** assert `i_rst` in B_SEND with `o_valid`=1 → after the edge all outputs are at reset values; the next B packet starts cleanly from B_LOAD.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx between a buffered echo stream (A) and a packet source (B); define UART_TX_ARB_DROP_CNT_EN for o_a_drops.
// Latency: echo byte reaches o_valid two edges after its strobe; B first byte two edges after i_b_valid, later bytes one edge after each send.
// Backpressure: i_ready stalls the output; A is never stalled (dropped when FIFO full); B is accepted only while o_b_ready (B_LOAD).

// Echo FIFO: a write into a full FIFO is still accepted when a pop happens in the same cycle.
module uart_tx_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_rd;
    logic          w_wr_ok;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_rd      = i_rd && !o_empty;
    assign w_wr_ok   = i_wr && (!w_full || w_rd);
    assign o_drop    = i_wr && !w_wr_ok;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_ok && !w_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_wr_ok && w_rd) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end
endmodule

module uart_tx_arb #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_a_data,
    input  logic       i_a_valid,
    output logic       o_a_overflow,
`ifdef UART_TX_ARB_DROP_CNT_EN
    output logic [7:0] o_a_drops,
`endif
    input  logic [7:0] i_b_data,
    input  logic       i_b_last,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_A_SEND, S_B_LOAD, S_B_SEND} state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t     r_state;
    logic       r_last;
    logic       r_b_last;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_overflow;

    logic [7:0] w_head;
    logic       w_empty;
    logic       w_drop;
    logic       w_a_pend;
    logic       w_b_pend;
    logic       w_grant_a;
    logic       w_grant_b;

    assign w_a_pend  = !w_empty;
    assign w_b_pend  = i_b_valid;
    // On a tie the requester that did not go last wins.
    assign w_grant_a = (r_state == S_IDLE) && w_a_pend && (!w_b_pend || (r_last == LAST_B));
    assign w_grant_b = (r_state == S_IDLE) && w_b_pend && (!w_a_pend || (r_last == LAST_A));

    uart_tx_arb_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_echo_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr      (i_a_valid),
        .i_wr_data (i_a_data),
        .i_rd      (w_grant_a),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_drop    (w_drop)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_last     <= LAST_B;
            r_b_last   <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a) begin
                        r_data  <= w_head;
                        r_valid <= 1'b1;
                        r_state <= S_A_SEND;
                    end else if (w_grant_b) begin
                        r_state <= S_B_LOAD;
                    end
                end
                S_A_SEND: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= LAST_A;
                        r_state <= S_IDLE;
                    end
                end
                S_B_LOAD: begin
                    if (i_b_valid) begin
                        r_data   <= i_b_data;
                        r_b_last <= i_b_last;
                        r_valid  <= 1'b1;
                        r_state  <= S_B_SEND;
                    end
                end
                S_B_SEND: begin
                    // The packet keeps the transmitter until its last byte is sent.
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        if (r_b_last) begin
                            r_last  <= LAST_B;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_B_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TX_ARB_DROP_CNT_EN
    logic [7:0] r_drops;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drops <= 8'd0;
        end else if (w_drop && (r_drops != 8'hFF)) begin
            r_drops <= r_drops + 8'd1;
        end
    end

    assign o_a_drops = r_drops;
`endif

    assign o_b_ready    = (r_state == S_B_LOAD);
    assign o_busy       = (r_state != S_IDLE);
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_a_overflow = r_overflow;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: expected output bytes are queued from ordering rules, a negedge monitor checks every downstream transfer.
module tb_uart_tx_arb;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_overflow;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
`ifdef UART_TX_ARB_DROP_CNT_EN
    logic [7:0] a_drops;
`endif

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    logic       rand_ready = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    uart_tx_arb #(.DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a_data     (a_data),
        .i_a_valid    (a_valid),
        .o_a_overflow (a_overflow),
`ifdef UART_TX_ARB_DROP_CNT_EN
        .o_a_drops    (a_drops),
`endif
        .i_b_data     (b_data),
        .i_b_last     (b_last),
        .i_b_valid    (b_valid),
        .o_b_ready    (b_ready),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold && valid) chk("data_stable", data, prev_data);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %0h, expected no transfer", data);
                end else begin
                    chk("out_byte", data, exp_q.pop_front());
                end
            end
            prev_hold = valid && !ready;
            prev_data = data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, valid, 0);
        chk({name, "_data"}, data, 8'h00);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_b_ready"}, b_ready, 0);
        chk({name, "_overflow"}, a_overflow, 0);
`ifdef UART_TX_ARB_DROP_CNT_EN
        chk({name, "_drops"}, a_drops, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; b_last = 1'b0; ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic strobe_a(input logic [7:0] d);
        a_data = d; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] pkt [8], input int len);
        for (int i = 0; i < len; i++) begin
            int  n = 0;
            logic got = 1'b0;
            b_valid = 1'b1; b_data = pkt[i]; b_last = (i == len - 1);
            while (!got && n < 500) begin
                @(negedge clk); got = b_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!got) begin
                checks++;
                $display("FAIL b_handshake_timeout: byte %0d not accepted, required acceptance within 500 cycles", i);
            end
        end
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic a_after_grant(input logic [7:0] av [8], input int k);
        int n = 0;
        while (!b_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        for (int i = 0; i < k; i++) strobe_a(av[i]);
    endtask

    task automatic packet_lock(input logic [7:0] pkt [8], input int len,
                               input logic [7:0] av [8], input int k, input logic rnd);
        for (int i = 0; i < len; i++) exp_q.push_back(pkt[i]);
        for (int i = 0; i < k; i++) exp_q.push_back(av[i]);
        ready = 1'b1; rand_ready = rnd;
        fork
            send_b(pkt, len);
            a_after_grant(av, k);
        join
        rand_ready = 1'b0; ready = 1'b1;
        wait_drain("packet_lock");
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] pkt [8];
        logic [7:0] av [8];
        int len, k, n, acc;

        rst = 1'b1; a_valid = 1'b0; a_data = 8'h00; b_valid = 1'b0; b_data = 8'h00;
        b_last = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Single echoes: latency and one-cycle valid with a ready sink.
        ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 8'h41 : 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            strobe_a(d);
            @(negedge clk); chk("echo_not_before_k1", valid, 0);
            @(negedge clk); chk("echo_valid_after_k1", valid, 1);
            @(negedge clk); chk("echo_one_cycle", valid, 0);
            chk("echo_busy_low", busy, 0);
            @(posedge clk); #1;
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end

        // Ties: A wins right after reset and again after a B packet.
        do_reset();
        ready = 1'b1;
        for (int it = 0; it < 2; it++) begin
            d      = (it == 0) ? 8'h31 : 8'($urandom_range(0, 255));
            pkt[0] = (it == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            pkt[1] = (it == 0) ? 8'h56 : 8'($urandom_range(0, 255));
            exp_q.push_back(d); exp_q.push_back(pkt[0]); exp_q.push_back(pkt[1]);
            strobe_a(d);
            send_b(pkt, 2);
            wait_drain("tie");
        end

        // Packet lock: echoes arriving mid-packet follow the whole packet.
        pkt[0] = 8'h10; pkt[1] = 8'h11; pkt[2] = 8'h12;
        av[0] = 8'h61; av[1] = 8'h62;
        packet_lock(pkt, 3, av, 2, 1'b0);
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(2, 5);
            k   = $urandom_range(1, DEPTH);
            for (int i = 0; i < 8; i++) begin
                pkt[i] = 8'($urandom_range(0, 255));
                av[i]  = 8'($urandom_range(0, 255));
            end
            packet_lock(pkt, len, av, k, 1'b1);
        end

        // Overflow: with the sink stalled, one byte sits in o_data and DEPTH wait in the FIFO.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n   = (it == 0) ? 6 : $urandom_range(1, 8);
            acc = (n < DEPTH + 1) ? n : DEPTH + 1;
            for (int i = 0; i < n; i++) begin
                d = (it == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
                if (i < acc) exp_q.push_back(d);
                strobe_a(d);
            end
            repeat (2) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("overflow_flag", a_overflow, (n > DEPTH + 1));
`ifdef UART_TX_ARB_DROP_CNT_EN
            chk("overflow_drops", a_drops, n - acc);
`endif
            @(posedge clk); #1 ready = 1'b1;
            wait_drain("overflow");
        end

        // Full FIFO with a write coincident with a pop: accepted, count stays DEPTH.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            av[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(av[i]);
            strobe_a(av[i]);
        end
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        repeat (2) begin @(posedge clk); #1; end
        ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        strobe_a(d);
        @(negedge clk); chk("fullpop_no_drop", a_overflow, 0);
        @(posedge clk); #1;
        strobe_a(8'hEE);
        @(negedge clk); chk("fullpop_count_full", a_overflow, 1);
`ifdef UART_TX_ARB_DROP_CNT_EN
        chk("fullpop_drops", a_drops, 1);
`endif
        @(posedge clk); #1 ready = 1'b1;
        wait_drain("fullpop");

        // Reset while a B byte is held in B_SEND; the byte is discarded.
        ready = 1'b0;
        b_data = 8'($urandom_range(0, 255)); b_last = 1'b0; b_valid = 1'b1;
        n = 0;
        while (!valid && n < 20) begin @(negedge clk); n++; end
        chk("rstmid_in_bsend", valid, 1);
        @(posedge clk); #1 rst = 1'b1; b_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid");
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            pkt[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(pkt[i]);
        end
        ready = 1'b1;
        fork
            send_b(pkt, 3);
            begin
                @(negedge clk); chk("rstmid_grant_cycle", b_ready, 0);
                @(negedge clk); chk("rstmid_b_load", b_ready, 1);
            end
        join
        wait_drain("rstmid");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
